// File: rtl/multi_clock_enable.sv
// Multi-channel programmable clock-enable generator with shadowed divisors and a global sync.
// Optional macro MULTI_CLOCK_ENABLE_SQUARE_EN adds a half-rate square-wave output sq per channel.

module multi_clock_enable #(
  parameter int unsigned CLK_FREQ     = 12_000_000,
  parameter int unsigned DEFAULT_FREQ = 6_000_000,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DIV_W        = 16,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] run,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DIV_W-1:0]  wr_div,
  output logic              wr_ready,
  output logic [NUM_CH-1:0] pending,
`ifdef MULTI_CLOCK_ENABLE_SQUARE_EN
  output logic [NUM_CH-1:0] sq,
`endif
  output logic [NUM_CH-1:0] en
);

  localparam int unsigned      DEFAULT_DIV = CLK_FREQ / DEFAULT_FREQ;
  localparam logic [DIV_W-1:0] DEF_DIV     = DIV_W'(DEFAULT_DIV);
  localparam logic [CH_W:0]    NUM_CH_L    = (CH_W + 1)'(NUM_CH);

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("multi_clock_enable: NUM_CH must be within 1..16");
  end
  if (DEFAULT_DIV == 0 || 64'(DEFAULT_DIV) >= (64'd1 << DIV_W)) begin : g_bad_div
    $error("multi_clock_enable: CLK_FREQ/DEFAULT_FREQ must be >= 1 and fit in DIV_W bits");
  end

  logic [DIV_W-1:0]  cnt_q [NUM_CH];
  logic [DIV_W-1:0]  cnt_d [NUM_CH];
  logic [DIV_W-1:0]  act_q [NUM_CH];
  logic [DIV_W-1:0]  act_d [NUM_CH];
  logic [DIV_W-1:0]  shd_q [NUM_CH];
  logic [DIV_W-1:0]  shd_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] wr_hit;
  logic              in_range;
`ifdef MULTI_CLOCK_ENABLE_SQUARE_EN
  logic [NUM_CH-1:0] sq_q, sq_d;
`endif

  // Reload value for a period of max(div,1) cycles: divisors 0 and 1 both pulse every cycle.
  function automatic logic [DIV_W-1:0] reload(input logic [DIV_W-1:0] div);
    return (div == '0) ? '0 : div - 1'b1;
  endfunction

  // Out-of-range channels always look ready so their writes are swallowed instead of hanging.
  always_comb begin
    in_range = ({1'b0, wr_ch} < NUM_CH_L);
    wr_ready = in_range ? !pend_q[wr_ch] : 1'b1;
    wr_hit   = '0;
    if (wr_en && wr_ready && in_range) wr_hit[wr_ch] = 1'b1;
  end

  always_comb begin
    // NOTE: every next-state signal gets a hold/default value first so no path leaves it unassigned (no latches).
    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    en_d   = '0;
`ifdef MULTI_CLOCK_ENABLE_SQUARE_EN
    sq_d   = sq_q;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (sync) begin
        cnt_d[i] = '0;
`ifdef MULTI_CLOCK_ENABLE_SQUARE_EN
        sq_d[i]  = 1'b0;
`endif
        // A write landing on the sync cycle bypasses the shadow and becomes active at once.
        if (wr_hit[i]) begin
          act_d[i]  = wr_div;
          pend_d[i] = 1'b0;
        end else if (pend_q[i]) begin
          act_d[i]  = shd_q[i];
          pend_d[i] = 1'b0;
        end
      end else begin
        if (run[i]) begin
          if (cnt_q[i] == '0) begin
            en_d[i] = 1'b1;
`ifdef MULTI_CLOCK_ENABLE_SQUARE_EN
            sq_d[i] = ~sq_q[i];
`endif
            if (pend_q[i]) begin
              act_d[i]  = shd_q[i];
              cnt_d[i]  = reload(shd_q[i]);
              pend_d[i] = 1'b0;
            end else begin
              cnt_d[i]  = reload(act_q[i]);
            end
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        // A write is only accepted while pend is clear, so it never collides with the wrap swap above.
        if (wr_hit[i]) begin
          shd_d[i]  = wr_div;
          pend_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these per-channel arrays are plain flops, not RAM, so they take the async reset like any register.
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        act_q[i] <= DEF_DIV;
        shd_q[i] <= DEF_DIV;
      end
      pend_q <= '0;
      en_q   <= '0;
`ifdef MULTI_CLOCK_ENABLE_SQUARE_EN
      sq_q   <= '0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      en_q   <= en_d;
`ifdef MULTI_CLOCK_ENABLE_SQUARE_EN
      sq_q   <= sq_d;
`endif
    end
  end

  assign pending = pend_q;
  assign en      = en_q;
`ifdef MULTI_CLOCK_ENABLE_SQUARE_EN
  assign sq      = sq_q;
`endif

endmodule

// File: tb/tb_multi_clock_enable.sv
// Self-checking bench for multi_clock_enable: vector table, directed corner sequences and
// randomized traffic checked against an interval-based reference model.

module tb_multi_clock_enable;
  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  run;
  logic        sync;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [15:0] wr_div;
  logic        wr_ready;
  logic [3:0]  pending;
  logic [3:0]  en;
`ifdef MULTI_CLOCK_ENABLE_SQUARE_EN
  logic [3:0]  sq;
`endif

  int total = 0;
  int bad   = 0;

  multi_clock_enable #(
    .CLK_FREQ(12_000_000), .DEFAULT_FREQ(6_000_000), .NUM_CH(NCH), .DIV_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .sync(sync),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
    .wr_ready(wr_ready), .pending(pending),
`ifdef MULTI_CLOCK_ENABLE_SQUARE_EN
    .sq(sq),
`endif
    .en(en)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Reference model: each channel tracks the running edges since its last pulse and the
  // length of the interval now in progress; a pulse fires when that interval is used up.
  int          m_since [NCH];
  int          m_per   [NCH];
  logic [15:0] m_act   [NCH];
  logic [15:0] m_shd   [NCH];
  logic [3:0]  m_pend, m_en, m_sq;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_since[i] = 0;
      m_per[i]   = 1;
      m_act[i]   = 16'd2;
      m_shd[i]   = 16'd2;
    end
    m_pend = '0;
    m_en   = '0;
    m_sq   = '0;
  endtask

  function automatic logic m_ready();
    return (int'(wr_ch) < NCH) ? !m_pend[wr_ch] : 1'b1;
  endfunction

  task automatic model_edge();
    logic acc;
    int   ch;
    acc = wr_en && m_ready();
    ch  = int'(wr_ch);
    for (int i = 0; i < NCH; i++) begin
      if (sync) begin
        m_since[i] = 0;
        m_per[i]   = 1;
        m_en[i]    = 1'b0;
        m_sq[i]    = 1'b0;
        if (acc && ch == i) begin
          m_act[i]  = wr_div;
          m_pend[i] = 1'b0;
        end else if (m_pend[i]) begin
          m_act[i]  = m_shd[i];
          m_pend[i] = 1'b0;
        end
      end else begin
        m_en[i] = 1'b0;
        if (run[i]) begin
          if (m_since[i] + 1 >= m_per[i]) begin
            m_en[i]    = 1'b1;
            m_sq[i]    = ~m_sq[i];
            m_since[i] = 0;
            if (m_pend[i]) begin
              m_act[i]  = m_shd[i];
              m_pend[i] = 1'b0;
            end
            m_per[i] = (m_act[i] == 16'd0) ? 1 : int'(m_act[i]);
          end else begin
            m_since[i]++;
          end
        end
        if (acc && ch == i) begin
          m_shd[i]  = wr_div;
          m_pend[i] = 1'b1;
        end
      end
    end
  endtask

  // One clock edge with the current inputs; outputs compared 1 time unit after the edge.
  task automatic tick();
    #1;
    check("wr_ready", wr_ready, m_ready());
    model_edge();
    @(posedge clk);
    #1;
    check("en", en, m_en);
    check("pending", pending, m_pend);
`ifdef MULTI_CLOCK_ENABLE_SQUARE_EN
    check("sq", sq, m_sq);
`endif
  endtask

  typedef struct {
    logic [3:0]  run;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [15:0] wr_div;
    logic        exp_ready;
    logic [3:0]  exp_en;
    logic [3:0]  exp_pend;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int cnt, first, n;
    logic acc;

    vecs[0]  = '{4'hF, 1'b0, 2'd0, 16'd0, 1'b1, 4'hF, 4'h0};
    vecs[1]  = '{4'hF, 1'b0, 2'd0, 16'd0, 1'b1, 4'h0, 4'h0};
    vecs[2]  = '{4'hF, 1'b0, 2'd0, 16'd0, 1'b1, 4'hF, 4'h0};
    vecs[3]  = '{4'hF, 1'b1, 2'd2, 16'd5, 1'b1, 4'h0, 4'h4};
    vecs[4]  = '{4'hF, 1'b1, 2'd2, 16'd9, 1'b0, 4'hF, 4'h0};
    vecs[5]  = '{4'hF, 1'b1, 2'd2, 16'd9, 1'b1, 4'h0, 4'h4};
    vecs[6]  = '{4'hF, 1'b0, 2'd2, 16'd0, 1'b0, 4'hB, 4'h4};
    vecs[7]  = '{4'hF, 1'b0, 2'd2, 16'd0, 1'b0, 4'h0, 4'h4};
    vecs[8]  = '{4'hF, 1'b0, 2'd2, 16'd0, 1'b0, 4'hB, 4'h4};
    vecs[9]  = '{4'hF, 1'b0, 2'd2, 16'd0, 1'b0, 4'h4, 4'h0};
    vecs[10] = '{4'hF, 1'b0, 2'd2, 16'd0, 1'b1, 4'hB, 4'h0};

    rst_n = 1'b0; run = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_en", en, 4'h0);
    check("reset_pending", pending, 4'h0);
    check("reset_wr_ready", wr_ready, 1'b1);
    rst_n = 1'b1;

    // Defaults, a mid-period write to ch2 and a stalled second write.
    for (int v = 0; v < 11; v++) begin
      run = vecs[v].run; wr_en = vecs[v].wr_en; wr_ch = vecs[v].wr_ch; wr_div = vecs[v].wr_div;
      #1;
      check($sformatf("tbl%0d_ready", v), wr_ready, vecs[v].exp_ready);
      tick();
      check($sformatf("tbl%0d_en", v), en, vecs[v].exp_en);
      check($sformatf("tbl%0d_pending", v), pending, vecs[v].exp_pend);
    end
    wr_en = 1'b0;

    // ch0 div=3, ch1 div=7, then a pending ch3 divisor swept in by sync.
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd3; tick();
    wr_ch = 2'd1; wr_div = 16'd7; tick();
    wr_en = 1'b0;
    repeat (6) tick();
    check("div_applied_pending", pending, 4'h0);
    run = 4'b0111;
    wr_en = 1'b1; wr_ch = 2'd3; wr_div = 16'd4; tick();
    wr_en = 1'b0; tick();
    check("ch3_staged", pending, 4'h8);
    sync = 1'b1; tick();
    sync = 1'b0;
    check("sync_en_clear", en, 4'h0);
    check("sync_pending_clear", pending, 4'h0);
    run = 4'hF; tick();
    check("sync_aligned_pulse", en, 4'hF);
    tick(); tick();

    // ch1 now holds a count of 4: stop it for 10 edges, then expect its pulse 5 edges after resuming.
    run = 4'b1101; tick();
    check("ch0_period3", en[1:0], 2'b01);
    cnt = 0;
    if (en[1]) cnt++;
    repeat (9) begin
      tick();
      if (en[1]) cnt++;
    end
    check("run_low_no_pulse", cnt, 0);
    run = 4'hF; first = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (en[1] && first == 0) first = k;
    end
    check("resume_latency", first, 5);

    // Divisor 0 behaves as 1: enable stays high once applied.
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd0; tick();
    wr_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!pending[0]) break;
    end
    check("div0_applied", pending[0], 1'b0);
    repeat (6) begin
      tick();
      check("div0_continuous", en[0], 1'b1);
    end

    // Randomized traffic; a stalled write is held stable until it is accepted.
    acc = 1'b1;
    for (int c = 0; c < 600; c++) begin
      run  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      sync = ($urandom_range(0, 39) == 0);
      if (!wr_en || acc) begin
        wr_en  = ($urandom_range(0, 2) == 0);
        wr_ch  = 2'($urandom_range(0, 3));
        wr_div = 16'($urandom_range(0, 9));
      end
      acc = wr_en && m_ready();
      tick();
    end
    sync = 1'b0; wr_en = 1'b0;

    // Asynchronous reset mid-period with a staged divisor.
    run = 4'b1011; wr_en = 1'b1; wr_ch = 2'd2; wr_div = 16'd6;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      acc = m_ready();
      tick();
      n++;
      if (acc) break;
    end
    wr_en = 1'b0;
    check("stage_before_reset", pending[2], 1'b1);
    run = 4'hF; tick();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset_en", en, 4'h0);
    check("async_reset_pending", pending, 4'h0);
    check("async_reset_ready", wr_ready, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_reset_default_div", en, (k % 2 == 0) ? 4'hF : 4'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
